// File: rtl/vga_sink.sv
// VGA capture sink: recovers raster geometry from hsync/vsync/valid, locks on, and strobes pixels with pixel and 9x16 character coordinates.
// Latency: 2 pclk cycles from an input sample to pix_we/pix_rgb (input register, then output register).
// Backpressure: none; pix_we is fire-and-forget with at most one strobe per cycle. Optional checker macro: VGA_SINK_CHECK_EN.
module vga_sink #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        valid,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        locked,
  output logic        pix_we,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic [6:0]  char_x,
  output logic [4:0]  char_y,
  output logic        frame_done,
  output logic [9:0]  meas_h_total,
  output logic [9:0]  meas_v_total,
  output logic [3:0]  timing_err
);

  typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;

  state_t      state, state_nx;
  logic        fd_nx;
  logic        hs_a, vs_a, de_a, hs_p, vs_p, de_p;
  logic [23:0] rgb_a;
  logic        hs_rise, vs_rise, de_fall;
  logic [9:0]  hcnt, lcnt, ref_v;
  logic [9:0]  x_ctr, y_ctr;
  logic [3:0]  col_sub, row_sub;
  logic [6:0]  col;
  logic [4:0]  row;

  // Stage A input register plus a one-cycle-old copy for edge detection.
  // Syncs reset to their idle (high) level so reset never fakes a sync edge.
  always_ff @(posedge pclk) begin
    if (reset) begin
      hs_a <= 1'b1; vs_a <= 1'b1; de_a <= 1'b0; rgb_a <= '0;
      hs_p <= 1'b1; vs_p <= 1'b1; de_p <= 1'b0;
    end else begin
      hs_a <= hsync; vs_a <= vsync; de_a <= valid; rgb_a <= {vga_r, vga_g, vga_b};
      hs_p <= hs_a;  vs_p <= vs_a;  de_p <= de_a;
    end
  end

  assign hs_rise = hs_a & ~hs_p;
  assign vs_rise = vs_a & ~vs_p;
  assign de_fall = ~de_a & de_p;

  // Line/frame length measurement; a simultaneous hs_rise counts into the freshly cleared lcnt.
  always_ff @(posedge pclk) begin
    if (reset) begin
      hcnt <= '0; lcnt <= '0; meas_h_total <= '0; meas_v_total <= '0;
    end else begin
      if (hs_rise) begin
        hcnt         <= 10'd1;
        meas_h_total <= hcnt;
      end else if (hcnt != 10'h3FF) begin
        hcnt <= hcnt + 10'd1;
      end
      if (vs_rise) begin
        meas_v_total <= lcnt;
        lcnt         <= hs_rise ? 10'd1 : 10'd0;
      end else if (hs_rise && lcnt != 10'h3FF) begin
        lcnt <= lcnt + 10'd1;
      end
    end
  end

  // FSM state, reference line count and frame_done register.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state <= ST_SEARCH; ref_v <= '0; frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_done <= fd_nx;
      if (state == ST_MEASURE && vs_rise) ref_v <= lcnt;
    end
  end

  // Lock sequencing: one frame to start measuring, one to confirm; a wrong frame length or lost vsync drops lock.
  always_comb begin
    state_nx = state;
    fd_nx    = 1'b0;
    case (state)
      ST_SEARCH:  if (vs_rise) state_nx = ST_MEASURE;
      ST_MEASURE: if (vs_rise && lcnt != 10'd0 && meas_h_total != 10'd0) state_nx = ST_LOCKED;
      ST_LOCKED: begin
        if (lcnt == 10'h3FF || (vs_rise && lcnt != ref_v)) state_nx = ST_SEARCH;
        else if (vs_rise) fd_nx = 1'b1;
      end
      default:    state_nx = ST_SEARCH;
    endcase
  end

  assign locked = (state == ST_LOCKED);

  // Active-area position and character-cell counters; they run regardless of lock state.
  always_ff @(posedge pclk) begin
    if (reset) begin
      x_ctr <= '0; y_ctr <= '0; col_sub <= '0; col <= '0; row_sub <= '0; row <= '0;
    end else begin
      if (de_fall) begin
        x_ctr <= '0; col_sub <= '0; col <= '0;
      end else if (de_a) begin
        if (x_ctr != 10'h3FF) x_ctr <= x_ctr + 10'd1;
        if (col_sub == 4'd8) begin
          col_sub <= '0;
          col     <= col + 7'd1;
        end else begin
          col_sub <= col_sub + 4'd1;
        end
      end
      if (vs_rise) begin
        y_ctr <= '0; row_sub <= '0; row <= '0;
      end else if (de_fall) begin
        y_ctr <= y_ctr + 10'd1;
        if (row_sub == 4'd15) begin
          row_sub <= '0;
          row     <= row + 5'd1;
        end else begin
          row_sub <= row_sub + 4'd1;
        end
      end
    end
  end

  // Pixel strobe and coordinates; coordinates and colour hold between strobes.
  always_ff @(posedge pclk) begin
    if (reset) begin
      pix_we <= 1'b0; pix_x <= '0; pix_y <= '0; char_x <= '0; char_y <= '0; pix_rgb <= '0;
    end else begin
      pix_we <= locked & de_a;
      if (locked && de_a) begin
        pix_x <= x_ctr; pix_y <= y_ctr; char_x <= col; char_y <= row; pix_rgb <= rgb_a;
      end
    end
  end

`ifdef VGA_SINK_CHECK_EN
  logic run_err;

  // Sticky geometry checks evaluated once per locked frame; lcnt is the value meas_v_total takes on this edge.
  always_ff @(posedge pclk) begin
    if (reset) begin
      timing_err <= '0; run_err <= 1'b0;
    end else if (vs_rise) begin
      if (locked) begin
        if (meas_h_total != 10'(H_TOTAL)) timing_err[0] <= 1'b1;
        if (lcnt != 10'(V_TOTAL))         timing_err[1] <= 1'b1;
        if (run_err || (de_fall && x_ctr != 10'(H_ACTIVE))) timing_err[2] <= 1'b1;
        if ((y_ctr + {9'd0, de_fall}) != 10'(V_ACTIVE)) timing_err[3] <= 1'b1;
      end
      run_err <= 1'b0;
    end else if (de_fall && x_ctr != 10'(H_ACTIVE)) begin
      run_err <= 1'b1;
    end
  end
`else
  // Geometry parameters only feed the optional checker.
  logic [39:0] geom_unused;
  assign geom_unused = {10'(H_ACTIVE), 10'(V_ACTIVE), 10'(H_TOTAL), 10'(V_TOTAL)};
  assign timing_err  = 4'd0;
`endif

endmodule

// File: tb/tb_vga_sink.sv
// Self-checking bench for vga_sink using a reduced 32x40 raster (18x32 active).
// Timing per line: hsync low x=1..4, valid x=8..25; per frame: vsync low lines 1..2, valid lines 5..36.
// Expected values are hand-computed for that raster.
module tb_vga_sink;

`ifdef VGA_SINK_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        reset, hsync, vsync, valid;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        locked, pix_we, frame_done;
  logic [9:0]  pix_x, pix_y, meas_h_total, meas_v_total;
  logic [23:0] pix_rgb;
  logic [6:0]  char_x;
  logic [4:0]  char_y;
  logic [3:0]  timing_err;

  vga_sink #(.H_ACTIVE(18), .V_ACTIVE(32), .H_TOTAL(32), .V_TOTAL(40)) dut (
    .pclk(pclk), .reset(reset), .hsync(hsync), .vsync(vsync), .valid(valid),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .locked(locked), .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .char_x(char_x), .char_y(char_y), .frame_done(frame_done),
    .meas_h_total(meas_h_total), .meas_v_total(meas_v_total), .timing_err(timing_err)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Driver controls
  int hot_x = -1, hot_y = -1, short_y = -1, rst_x = -1, rst_y = -1;
  logic [23:0] hot_rgb = '0;
  bit  vs_force = 1'b0;
  int  cur_line = 0;
  int  hot_in_cyc = 0, vs_in_cyc = 0;
  logic [82:0] rst_snap = '1;

  // Monitor state
  int n_we = 0, n_hot = 0, n_fd = 0;
  int hot_cyc = 0, lock_cyc = 0, unlock_line = 0, we_at_unlock = 0;
  logic [9:0]  last_x = '0, last_y = '0, hot_px = '0, hot_py = '0;
  logic [6:0]  last_cx = '0, hot_cx = '0;
  logic [4:0]  last_cy = '0, hot_cy = '0;
  logic [23:0] hot_rgb_o = '0;
  logic        lock_prev = 1'b0;

  always @(negedge pclk) begin
    if (pix_we) begin
      n_we = n_we + 1;
      last_x = pix_x; last_y = pix_y; last_cx = char_x; last_cy = char_y;
      if (pix_rgb != 24'h0) begin
        n_hot = n_hot + 1;
        hot_px = pix_x; hot_py = pix_y; hot_cx = char_x; hot_cy = char_y;
        hot_rgb_o = pix_rgb; hot_cyc = cyc;
      end
    end
    if (frame_done) n_fd = n_fd + 1;
    if (locked && !lock_prev) lock_cyc = cyc;
    if (!locked && lock_prev) begin
      unlock_line = cur_line;
      we_at_unlock = n_we;
    end
    lock_prev = locked;
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic gen_line(input int y);
    for (int x = 0; x < 32; x++) begin
      hsync = !(x >= 1 && x <= 4);
      vsync = vs_force ? 1'b1 : !(y >= 1 && y <= 2);
      valid = (y >= 5 && y <= 36) && (x >= 8) && (x <= ((y == short_y) ? 24 : 25));
      {vga_r, vga_g, vga_b} = (x == hot_x && y == hot_y) ? hot_rgb : 24'h0;
      if (x == hot_x && y == hot_y) hot_in_cyc = cyc;
      if (y == 3 && x == 0 && !vs_force) vs_in_cyc = cyc;
      reset = (x == rst_x && y == rst_y);
      @(posedge pclk); #1;
      if (reset) rst_snap = {locked, pix_we, frame_done, pix_x, pix_y, char_x, char_y,
                             pix_rgb, meas_h_total, meas_v_total, timing_err};
    end
    reset = 1'b0;
  endtask

  task automatic gen_frame(input int n);
    for (int y = 1; y <= n; y++) begin
      cur_line = y;
      gen_line(y);
    end
  endtask

  typedef struct {
    int          in_x;
    int          in_y;
    logic [23:0] rgb;
    logic [9:0]  px;
    logic [9:0]  py;
    logic [6:0]  cx;
    logic [4:0]  cy;
  } vec_t;

  vec_t tbl [6];
  int   w0, h0, f0;

  initial begin
    tbl[0] = '{in_x: 17, in_y: 21, rgb: 24'hFFFFFF, px: 10'd9,  py: 10'd16, cx: 7'd1, cy: 5'd1};
    tbl[1] = '{in_x: 8,  in_y: 5,  rgb: 24'h123456, px: 10'd0,  py: 10'd0,  cx: 7'd0, cy: 5'd0};
    tbl[2] = '{in_x: 25, in_y: 36, rgb: 24'hA5A5A5, px: 10'd17, py: 10'd31, cx: 7'd1, cy: 5'd1};
    tbl[3] = '{in_x: 16, in_y: 20, rgb: 24'h0000FF, px: 10'd8,  py: 10'd15, cx: 7'd0, cy: 5'd0};
    tbl[4] = '{in_x: 12, in_y: 6,  rgb: 24'hFF0000, px: 10'd4,  py: 10'd1,  cx: 7'd0, cy: 5'd0};
    tbl[5] = '{in_x: 25, in_y: 5,  rgb: 24'h00FF00, px: 10'd17, py: 10'd0,  cx: 7'd1, cy: 5'd0};

    // Reset state
    reset = 1'b1; hsync = 1'b1; vsync = 1'b1; valid = 1'b0;
    vga_r = 8'h0; vga_g = 8'h0; vga_b = 8'h0;
    repeat (4) begin @(posedge pclk); #1; end
    chk("rst_locked", locked, 0);
    chk("rst_pix_we", pix_we, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_coords", {pix_x, pix_y, char_x, char_y}, 0);
    chk("rst_rgb", pix_rgb, 0);
    chk("rst_meas", {meas_h_total, meas_v_total}, 0);
    chk("rst_err", timing_err, 0);
    reset = 1'b0;

    // Acquire lock: first frame measures, second locks
    w0 = n_we; gen_frame(40);
    chk("f1_locked", locked, 0);
    chk("f1_strobes", n_we - w0, 0);
    w0 = n_we; f0 = n_fd; gen_frame(40);
    chk("f2_locked", locked, 1);
    chk("lock_latency", lock_cyc - vs_in_cyc, 2);
    chk("f2_strobes", n_we - w0, 576);
    chk("f2_fd", n_fd - f0, 0);
    chk("meas_h", meas_h_total, 32);
    chk("meas_v", meas_v_total, 40);
    chk("last_px", last_x, 17);
    chk("last_py", last_y, 31);
    chk("last_cx", last_cx, 1);
    chk("last_cy", last_cy, 1);
    f0 = n_fd; gen_frame(40);
    chk("f3_fd", n_fd - f0, 1);
    chk("f3_err", timing_err, 0);

    // Single coloured pixel at various positions
    for (int i = 0; i < 6; i++) begin
      hot_x = tbl[i].in_x; hot_y = tbl[i].in_y; hot_rgb = tbl[i].rgb;
      w0 = n_we; h0 = n_hot; f0 = n_fd;
      gen_frame(40);
      chk($sformatf("v%0d_hot_count", i), n_hot - h0, 1);
      chk($sformatf("v%0d_pix_x", i), hot_px, tbl[i].px);
      chk($sformatf("v%0d_pix_y", i), hot_py, tbl[i].py);
      chk($sformatf("v%0d_char_x", i), hot_cx, tbl[i].cx);
      chk($sformatf("v%0d_char_y", i), hot_cy, tbl[i].cy);
      chk($sformatf("v%0d_rgb", i), hot_rgb_o, tbl[i].rgb);
      chk($sformatf("v%0d_latency", i), hot_cyc - hot_in_cyc, 2);
      chk($sformatf("v%0d_strobes", i), n_we - w0, 576);
      chk($sformatf("v%0d_fd", i), n_fd - f0, 1);
    end
    hot_x = -1; hot_y = -1;

    // One short line (17 valid cycles), flagged at the next locked vsync
    short_y = 10; gen_frame(40); short_y = -1;
    gen_frame(40);
    chk("short_line_err", timing_err, CHK ? 4'h4 : 4'h0);
    chk("short_line_locked", locked, 1);

    // One frame of 41 lines: lock drops at the following vsync with no frame_done
    gen_frame(41);
    w0 = n_we; f0 = n_fd; gen_frame(40);
    chk("long_frame_locked", locked, 0);
    chk("long_frame_fd", n_fd - f0, 0);
    chk("long_frame_strobes", n_we - w0, 0);
    chk("long_frame_err", timing_err, CHK ? 4'h6 : 4'h0);
    w0 = n_we; gen_frame(40);
    chk("relock1_strobes", n_we - w0, 0);
    gen_frame(40);
    chk("relock1_locked", locked, 1);
    chk("err_sticky", timing_err, CHK ? 4'h6 : 4'h0);

    // vsync lost: lcnt saturates 985 lines into the loss (38 already counted)
    vs_force = 1'b1;
    for (int n = 1; n <= 1000; n++) begin
      cur_line = n;
      gen_line(((n - 1) % 40) + 1);
    end
    vs_force = 1'b0;
    chk("lost_locked", locked, 0);
    chk("lost_unlock_line", unlock_line, 985);
    chk("lost_no_strobes", n_we - we_at_unlock, 0);
    w0 = n_we; gen_frame(40);
    chk("relock2_strobes", n_we - w0, 0);
    chk("relock2_meas_v_sat", meas_v_total, 1023);
    gen_frame(40);
    chk("relock2_locked", locked, 1);
    chk("relock2_meas_v", meas_v_total, 40);

    // Reset mid-frame at line 20, inside the active run
    for (int y = 1; y <= 19; y++) begin cur_line = y; gen_line(y); end
    rst_x = 10; rst_y = 20;
    for (int y = 20; y <= 40; y++) begin cur_line = y; gen_line(y); end
    rst_x = -1; rst_y = -1;
    chk("midrst_outputs", rst_snap, 0);
    chk("midrst_locked", locked, 0);
    w0 = n_we; gen_frame(40);
    chk("midrst_f1_strobes", n_we - w0, 0);
    chk("midrst_f1_locked", locked, 0);
    w0 = n_we; gen_frame(40);
    chk("midrst_f2_locked", locked, 1);
    chk("midrst_lock_latency", lock_cyc - vs_in_cyc, 2);
    chk("midrst_f2_strobes", n_we - w0, 576);
    chk("final_err", timing_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
